fifo_pack_upsizer: RTL and testbench
====================================

# fifo_pack_upsizer

Width up-converter that sits directly downstream of the first-word-fall-through FIFO read port. It pops narrow beats from the FIFO, packs `PACK_RATIO` consecutive beats into one wide word (beat 0 in the least-significant lane), and presents the word on a valid/ready interface. It sustains one FIFO pop per cycle, including while a previous wide word is held waiting for `out_ready_i`.

## Interface
- `DATA_WIDTH`, default 8: width of one FIFO beat.
- `PACK_RATIO`, default 4: beats per output word; legal range 2..16.
- `CNT_WIDTH`, default `$clog2(PACK_RATIO)`: width of the lane counter.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `empty_i`  in  1: FIFO empty; `rdata_i` is valid whenever this is 0 (FWFT).
- `rdata_i`  in  DATA_WIDTH: FIFO head data.
- `ren_o`  out  1: pop request to the FIFO; a beat is consumed on any edge where `ren_o`=1 and `empty_i`=0.
- `out_valid_o`  out  1: wide word available.
- `out_ready_i`  in  1: downstream accepts the word.
- `out_data_o`  out  DATA_WIDTH*PACK_RATIO: packed word; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- `out_keep_o`  out  PACK_RATIO: per-lane valid mask.
- `lane_cnt_o`  out  CNT_WIDTH: beats held in the assembly buffer.
- `flush_i`  in  1: present only when FIFO_PACK_FLUSH_EN is defined.

## Operation
- State: assembly lanes 0..PACK_RATIO-2, `lane_cnt`, output register (`out_data`, `out_keep`, `out_valid`).
- `out_free` = !`out_valid_o` || `out_ready_i`.
- `ren_o` = !`empty_i` && !(`lane_cnt`==PACK_RATIO-1 && !`out_free`) && !`flush_pend`. This signal is combinational from registered state, `empty_i` and `out_ready_i`.
- Pop with `lane_cnt` < PACK_RATIO-1: lane[`lane_cnt`] <= `rdata_i`, `lane_cnt`++.
- Pop with `lane_cnt` == PACK_RATIO-1 (completing beat):
  - `out_data` <= {`rdata_i`, lanes[PACK_RATIO-2:0]}.
  - `out_keep` <= all ones.
  - `out_valid` <= 1, `lane_cnt` <= 0.
  - The completing beat bypasses the assembly lanes.
- Output handshake:
  - A word transfers on any edge with `out_valid_o`=1 and `out_ready_i`=1.
  - `out_valid` clears on that edge unless a new word loads on the same edge; in that case it stays 1 with the new data.
- Held word (`out_valid_o`=1, `out_ready_i`=0): `out_data_o` and `out_keep_o` are stable. Partial assembly continues up to PACK_RATIO-1 beats, then `ren_o` drops.
- `empty_i`=1: no pop. Partial words are held indefinitely; there is no timeout.

## Timing
- Reset values: `out_valid_o`=0, `out_data_o`=0, `out_keep_o`=0, `lane_cnt_o`=0, lanes=0, `flush_pend`=0.
- During reset, `ren_o` = !`empty_i`; the FIFO is in reset and reports empty, so `ren_o` is 0.
- Reset asserted mid-word discards partial lanes and any held output word immediately, without waiting for a clock edge.
- Latency: `out_valid_o` rises on the same edge that pops beat PACK_RATIO-1. Data appears one cycle after the last beat is presented.
- Throughput:
  - With `out_ready_i` tied 1: one word every PACK_RATIO cycles and zero pop stalls.
  - With `out_ready_i` tied 0 after one word: exactly PACK_RATIO-1 further pops, then `ren_o`=0.
- `lane_cnt_o` wraps from PACK_RATIO-1 to 0 only on a completing pop or a flush emit.

## Configuration
- `FIFO_PACK_FLUSH_EN` defined:
  - Adds the `flush_i` port.
  - `flush_i`=1 at an edge sets `flush_pend` if `lane_cnt` > 0 after that edge's pop. The pop uses the pre-flush `ren_o`, so a beat accepted on the same edge is included in the flush.
  - While `flush_pend`=1, `ren_o`=0.
  - On the first edge with `out_free`=1: `out_data` <= lanes in the low lanes and zeros above; `out_keep` <= (1<<`lane_cnt`)-1; `out_valid` <= 1; `lane_cnt` <= 0; `flush_pend` <= 0.
  - `flush_i` with `lane_cnt`=0 is ignored.
- Not defined: no `flush_i` port, `flush_pend` is constant 0, `out_keep_o` is all ones whenever `out_valid_o`=1 (0 after reset), and partial words are never emitted.

## Test plan
- Reset with defaults, `empty_i`=1 -> all outputs 0 and `ren_o`=0; assert `rst_n` mid-word after 2 beats -> `lane_cnt_o`=0 and `out_valid_o`=0 asynchronously.
- Stream beats 0x01..0x08, `out_ready_i`=1 -> words 0x04030201 then 0x08070605, keep 0xF, `ren_o` continuously 1 for 8 cycles.
- Complete word 0x04030201 with `out_ready_i`=0, then offer 0x05..0x08 -> 0x05..0x07 are popped, `ren_o`=0 on 0x08 and `out_data_o` stable; raise `out_ready_i` -> 0x08 pops on the same edge the first word transfers, and 0x08070605 is valid on the next cycle.
- FIFO goes empty after beats 0xAA, 0xBB -> `lane_cnt_o`=2 with no output; refill with 0xCC, 0xDD -> word 0xDDCCBBAA.
- With FIFO_PACK_FLUSH_EN: 3 beats 0x11, 0x22, 0x33, then `flush_i` -> word 0x00332211 with keep 0x7 and `ren_o`=0 until emitted; `flush_i` with `lane_cnt_o`=0 -> no output.
- With FIFO_PACK_FLUSH_EN: `flush_i` on the same edge as a pop of 0x44 while `lane_cnt`=1 after 0x11 -> word 0x00004411 with keep 0x3.

Source files
------------

// File: rtl/fifo_pack_upsizer_if.sv
// FIFO-read-port and wide-word handshake bundle for the beat packer.
// flush_i exists only when FIFO_PACK_FLUSH_EN is defined.
interface fifo_pack_upsizer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 4,
   parameter int CNT_WIDTH  = $clog2(PACK_RATIO)
);
   logic                           empty_i;
   logic [DATA_WIDTH-1:0]          rdata_i;
   logic                           ren_o;
   logic                           out_valid_o;
   logic                           out_ready_i;
   logic [DATA_WIDTH*PACK_RATIO-1:0] out_data_o;
   logic [PACK_RATIO-1:0]          out_keep_o;
   logic [CNT_WIDTH-1:0]           lane_cnt_o;
`ifdef FIFO_PACK_FLUSH_EN
   logic                           flush_i;
`endif

   modport master (
      output empty_i, rdata_i, out_ready_i,
`ifdef FIFO_PACK_FLUSH_EN
      output flush_i,
`endif
      input  ren_o, out_valid_o, out_data_o,
      input  out_keep_o, lane_cnt_o
   );

   modport slave (
      input  empty_i, rdata_i, out_ready_i,
`ifdef FIFO_PACK_FLUSH_EN
      input  flush_i,
`endif
      output ren_o, out_valid_o, out_data_o,
      output out_keep_o, lane_cnt_o
   );
endinterface

// File: rtl/fifo_pack_upsizer.sv
// Packs PACK_RATIO narrow FWFT FIFO beats into one wide valid/ready word.
// Optional partial-word flush: define FIFO_PACK_FLUSH_EN.
module fifo_pack_upsizer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 4,
   parameter int CNT_WIDTH  = $clog2(PACK_RATIO)
) (
   input logic clk,
   input logic rst_n,
   fifo_pack_upsizer_if.slave bus
);
   localparam int OW = DATA_WIDTH * PACK_RATIO;
   localparam int LW = DATA_WIDTH * (PACK_RATIO - 1);
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(PACK_RATIO - 1);

   logic [LW-1:0]         lanes;
   logic [CNT_WIDTH-1:0]  lane_cnt;
   logic [OW-1:0]         out_data;
   logic [PACK_RATIO-1:0] out_keep;
   logic                  out_valid;
   logic                  flush_pend;
   logic                  flush_emit;
   logic [OW-1:0]         flush_data;
   logic [PACK_RATIO-1:0] flush_keep;
   logic                  out_free;
   logic                  last;
   logic                  ren;
   logic                  load;
   logic                  xfer;

   assign out_free = !out_valid || bus.out_ready_i;
   assign last     = lane_cnt == LAST;
   assign ren      = !bus.empty_i && !(last && !out_free) && !flush_pend;
   assign load     = ren && last;
   assign xfer     = out_valid && bus.out_ready_i;

`ifdef FIFO_PACK_FLUSH_EN
   logic [CNT_WIDTH-1:0] cnt_after;

   // occupancy after this edge's pop decides whether a flush is needed
   assign cnt_after  = ren ? (last ? '0 : lane_cnt + CNT_WIDTH'(1))
                           : lane_cnt;
   assign flush_emit = flush_pend && out_free;

   always_comb begin
      flush_data = '0;
      flush_keep = '0;
      for (int k = 0; k < PACK_RATIO - 1; k++) begin
         if (CNT_WIDTH'(k) < lane_cnt) begin
            flush_data[k*DATA_WIDTH +: DATA_WIDTH] =
               lanes[k*DATA_WIDTH +: DATA_WIDTH];
            flush_keep[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_pend <= 1'b0;
      end else if (flush_emit) begin
         flush_pend <= 1'b0;
      end else if (bus.flush_i && cnt_after != '0) begin
         flush_pend <= 1'b1;
      end
   end
`else
   assign flush_pend = 1'b0;
   assign flush_emit = 1'b0;
   assign flush_data = '0;
   assign flush_keep = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes     <= '0;
         lane_cnt  <= '0;
         out_data  <= '0;
         out_keep  <= '0;
         out_valid <= 1'b0;
      end else begin
         // the completing beat goes straight to the output register
         if (load) begin
            out_data  <= {bus.rdata_i, lanes};
            out_keep  <= '1;
            out_valid <= 1'b1;
         end else if (flush_emit) begin
            out_data  <= flush_data;
            out_keep  <= flush_keep;
            out_valid <= 1'b1;
         end else if (xfer) begin
            out_valid <= 1'b0;
         end

         if (ren && !last) begin
            for (int k = 0; k < PACK_RATIO - 1; k++) begin
               if (lane_cnt == CNT_WIDTH'(k)) begin
                  lanes[k*DATA_WIDTH +: DATA_WIDTH] <= bus.rdata_i;
               end
            end
            lane_cnt <= lane_cnt + CNT_WIDTH'(1);
         end else if (load || flush_emit) begin
            lane_cnt <= '0;
         end
      end
   end

   assign bus.ren_o       = ren;
   assign bus.out_valid_o = out_valid;
   assign bus.out_data_o  = out_data;
   assign bus.out_keep_o  = out_keep;
   assign bus.lane_cnt_o  = lane_cnt;
endmodule

// File: tb/tb_fifo_pack_upsizer.sv
// Bench for fifo_pack_upsizer: directed vector table, corner sequences,
// and randomized traffic against a queue-based packing model.
module tb_fifo_pack_upsizer;
   localparam int DW = 8;
   localparam int PR = 4;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic flush_drv;
   int   errs = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   fifo_pack_upsizer_if #(
      .DATA_WIDTH(DW), .PACK_RATIO(PR), .CNT_WIDTH(CW)
   ) bus ();

   fifo_pack_upsizer #(
      .DATA_WIDTH(DW), .PACK_RATIO(PR), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

`ifdef FIFO_PACK_FLUSH_EN
   assign bus.flush_i = flush_drv;
`endif

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [7:0] d,
                        input logic r, input logic f);
      bus.empty_i     = e;
      bus.rdata_i     = d;
      bus.out_ready_i = r;
      flush_drv       = f;
   endtask

   task automatic cyc(input logic e, input logic [7:0] d,
                      input logic r, input logic f);
      drive(e, d, r, f);
      @(posedge clk);
      #1;
   endtask

   // behavioural reference: queue of assembled beats plus output word
   logic [7:0]  m_asm[$];
   logic        m_valid;
   logic        m_pend;
   logic [31:0] m_data;
   logic [3:0]  m_keep;

   task automatic m_reset();
      m_asm.delete();
      m_valid = 0;
      m_pend  = 0;
      m_data  = 0;
      m_keep  = 0;
   endtask

   function automatic logic m_ren(input logic e, input logic r);
      logic free;
      free = !m_valid || r;
      return !e && !(m_asm.size() == PR - 1 && !free) && !m_pend;
   endfunction

   function automatic logic [31:0] m_pack();
      logic [31:0] w;
      w = 0;
      foreach (m_asm[i]) w |= 32'(m_asm[i]) << (8 * i);
      return w;
   endfunction

   task automatic m_step(input logic e, input logic [7:0] d,
                         input logic r, input logic f);
      logic free, rd, nw, emit;
      free = !m_valid || r;
      rd   = m_ren(e, r);
      nw   = 0;
      emit = m_pend && free;
      if (emit) begin
         m_data  = m_pack();
         m_keep  = 4'((1 << m_asm.size()) - 1);
         m_valid = 1;
         m_asm.delete();
         m_pend  = 0;
         nw      = 1;
      end else if (rd) begin
         m_asm.push_back(d);
         if (m_asm.size() == PR) begin
            m_data  = m_pack();
            m_keep  = 4'hF;
            m_valid = 1;
            m_asm.delete();
            nw      = 1;
         end
      end
      if (!emit && f && m_asm.size() > 0) m_pend = 1;
      if (!nw && m_valid && r) m_valid = 0;
   endtask

   typedef struct {
      logic        empty;
      logic [7:0]  rdata;
      logic        ready;
      logic        ren;
      logic [1:0]  cnt;
      logic        valid;
      logic [31:0] data;
   } vec_t;

   vec_t tbl[27];

   initial begin
      tbl[0]  = '{0, 8'h01, 1, 1, 2'd1, 0, 32'h0};
      tbl[1]  = '{0, 8'h02, 1, 1, 2'd2, 0, 32'h0};
      tbl[2]  = '{0, 8'h03, 1, 1, 2'd3, 0, 32'h0};
      tbl[3]  = '{0, 8'h04, 1, 1, 2'd0, 1, 32'h04030201};
      tbl[4]  = '{0, 8'h05, 1, 1, 2'd1, 0, 32'h0};
      tbl[5]  = '{0, 8'h06, 1, 1, 2'd2, 0, 32'h0};
      tbl[6]  = '{0, 8'h07, 1, 1, 2'd3, 0, 32'h0};
      tbl[7]  = '{0, 8'h08, 1, 1, 2'd0, 1, 32'h08070605};
      tbl[8]  = '{1, 8'h00, 1, 0, 2'd0, 0, 32'h0};
      tbl[9]  = '{0, 8'h01, 0, 1, 2'd1, 0, 32'h0};
      tbl[10] = '{0, 8'h02, 0, 1, 2'd2, 0, 32'h0};
      tbl[11] = '{0, 8'h03, 0, 1, 2'd3, 0, 32'h0};
      tbl[12] = '{0, 8'h04, 0, 1, 2'd0, 1, 32'h04030201};
      tbl[13] = '{0, 8'h05, 0, 1, 2'd1, 1, 32'h04030201};
      tbl[14] = '{0, 8'h06, 0, 1, 2'd2, 1, 32'h04030201};
      tbl[15] = '{0, 8'h07, 0, 1, 2'd3, 1, 32'h04030201};
      tbl[16] = '{0, 8'h08, 0, 0, 2'd3, 1, 32'h04030201};
      tbl[17] = '{0, 8'h08, 0, 0, 2'd3, 1, 32'h04030201};
      tbl[18] = '{0, 8'h08, 1, 1, 2'd0, 1, 32'h08070605};
      tbl[19] = '{1, 8'h00, 1, 0, 2'd0, 0, 32'h0};
      tbl[20] = '{0, 8'hAA, 1, 1, 2'd1, 0, 32'h0};
      tbl[21] = '{0, 8'hBB, 1, 1, 2'd2, 0, 32'h0};
      tbl[22] = '{1, 8'h00, 1, 0, 2'd2, 0, 32'h0};
      tbl[23] = '{1, 8'h00, 1, 0, 2'd2, 0, 32'h0};
      tbl[24] = '{0, 8'hCC, 1, 1, 2'd3, 0, 32'h0};
      tbl[25] = '{0, 8'hDD, 1, 1, 2'd0, 1, 32'hDDCCBBAA};
      tbl[26] = '{1, 8'h00, 1, 0, 2'd0, 0, 32'h0};

      rst_n = 1'b0;
      drive(1, 8'h00, 0, 0);
      #12;
      chk("rst_ren", bus.ren_o, 0);
      chk("rst_valid", bus.out_valid_o, 0);
      chk("rst_data", bus.out_data_o, 0);
      chk("rst_keep", bus.out_keep_o, 0);
      chk("rst_cnt", bus.lane_cnt_o, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].empty, tbl[i].rdata, tbl[i].ready, 0);
         #1;
         chk($sformatf("tbl%0d_ren", i), bus.ren_o, tbl[i].ren);
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_cnt", i), bus.lane_cnt_o, tbl[i].cnt);
         chk($sformatf("tbl%0d_valid", i), bus.out_valid_o,
             tbl[i].valid);
         if (tbl[i].valid) begin
            chk($sformatf("tbl%0d_data", i), bus.out_data_o,
                tbl[i].data);
            chk($sformatf("tbl%0d_keep", i), bus.out_keep_o, 4'hF);
         end
      end

      // held word plus two partial beats, then asynchronous reset
      for (int i = 1; i <= 6; i++) cyc(0, 8'(i), 0, 0);
      chk("pre_arst_cnt", bus.lane_cnt_o, 2);
      chk("pre_arst_valid", bus.out_valid_o, 1);
      drive(1, 8'h00, 0, 0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_cnt", bus.lane_cnt_o, 0);
      chk("arst_valid", bus.out_valid_o, 0);
      chk("arst_data", bus.out_data_o, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

`ifdef FIFO_PACK_FLUSH_EN
      cyc(0, 8'h11, 1, 0);
      cyc(0, 8'h22, 1, 0);
      cyc(0, 8'h33, 1, 0);
      chk("fl_cnt3", bus.lane_cnt_o, 3);
      drive(1, 8'h00, 1, 1);
      @(posedge clk);
      #1;
      chk("fl_pend_valid", bus.out_valid_o, 0);
      drive(0, 8'h44, 1, 0);
      #1;
      chk("fl_ren_block", bus.ren_o, 0);
      @(posedge clk);
      #1;
      chk("fl_valid", bus.out_valid_o, 1);
      chk("fl_data", bus.out_data_o, 32'h00332211);
      chk("fl_keep", bus.out_keep_o, 4'h7);
      chk("fl_cnt0", bus.lane_cnt_o, 0);
      cyc(1, 8'h00, 1, 1);
      chk("fl_idle_v0", bus.out_valid_o, 0);
      cyc(1, 8'h00, 1, 0);
      chk("fl_idle_v1", bus.out_valid_o, 0);
      cyc(0, 8'h11, 1, 0);
      drive(0, 8'h44, 1, 1);
      #1;
      chk("fl_same_ren", bus.ren_o, 1);
      @(posedge clk);
      #1;
      chk("fl_same_cnt", bus.lane_cnt_o, 2);
      drive(1, 8'h00, 1, 0);
      #1;
      chk("fl_same_ren0", bus.ren_o, 0);
      @(posedge clk);
      #1;
      chk("fl_same_valid", bus.out_valid_o, 1);
      chk("fl_same_data", bus.out_data_o, 32'h00004411);
      chk("fl_same_keep", bus.out_keep_o, 4'h3);
      cyc(1, 8'h00, 1, 0);
`endif

      drive(1, 8'h00, 0, 0);
      #1;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      m_reset();
      @(posedge clk);
      #1;

      for (int n = 0; n < 600; n++) begin
         logic e, r, f;
         logic [7:0] d;
         int rbias;
         rbias = (n / 100) % 3;
         e = ($urandom_range(0, 3) == 0);
         d = 8'($urandom);
         r = (rbias == 0) ? 1'b1 :
             (rbias == 1) ? ($urandom_range(0, 3) == 0) :
                            ($urandom_range(0, 1) == 0);
`ifdef FIFO_PACK_FLUSH_EN
         f = ($urandom_range(0, 15) == 0);
`else
         f = 1'b0;
`endif
         drive(e, d, r, f);
         #1;
         chk("rnd_ren", bus.ren_o, m_ren(e, r));
         @(posedge clk);
         m_step(e, d, r, f);
         #1;
         chk("rnd_valid", bus.out_valid_o, m_valid);
         chk("rnd_cnt", bus.lane_cnt_o, m_asm.size());
         if (m_valid) begin
            chk("rnd_data", bus.out_data_o, m_data);
            chk("rnd_keep", bus.out_keep_o, m_keep);
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
